// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the rv32 memory-side bridge.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WS,
    IO_WAIT
  } bridge_state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  function automatic logic is_io(input logic [31:0] addr, input int io_bit);
    return addr[io_bit];
  endfunction

endpackage

// File: rtl/rv_mem_bridge.sv
// Decodes core memory accesses to sync SRAM or the IO bus.
// IO accesses are timed out and reported through a sticky error flag.
module rv_mem_bridge
  import rv_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int IO_BIT     = 22,
  parameter int RAM_AW     = 14,
  parameter int RAM_WAIT   = 0,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wmask,
  input  logic              mem_rstrb,
  output logic [31:0]       mem_rdata,
  output logic              mem_rbusy,
  output logic              mem_wbusy,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_valid,
  output logic              io_we,
  output logic [3:0]        io_wmask,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic              io_ready,
  input  logic [31:0]       io_rdata,
  output logic              bus_err,
  input  logic              err_clr
);

  localparam int          TW         = $clog2(IO_TIMEOUT + 1);
  localparam bit          RAM_DIRECT = (RAM_WAIT == 0);
  localparam logic [31:0] ADDR_MASK  = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'h1 << ADDR_WIDTH) - 32'h1);

  bridge_state_e state, next_state;

  logic [TW-1:0] tmo_cnt;
  logic [3:0]    ws_cnt;
  logic [31:0]   rdata_q;
  logic          src_ram;

  logic req_write;
  logic req_any;
  logic addr_io;
  logic accept;
  logic ws_last;
  logic tmo_hit;

  assign req_write = |mem_wmask;
  assign req_any   = req_write | mem_rstrb;
  assign addr_io   = is_io(mem_addr & ADDR_MASK, IO_BIT);
  assign ws_last   = (ws_cnt == 4'(RAM_WAIT - 1));
  assign tmo_hit   = (state == IO_WAIT) && !io_ready && (tmo_cnt == TW'(IO_TIMEOUT - 1));

  assign ram_addr  = mem_addr[RAM_AW+1:2];
  assign ram_wdata = mem_wdata;
  assign mem_rdata = src_ram ? ram_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    next_state = state;
    accept     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 4'h0;
    mem_rbusy  = 1'b0;
    mem_wbusy  = 1'b0;
    case (state)
      IDLE: begin
        // The rst term keeps the SRAM strobes quiet while reset is held.
        if (req_any && rst) begin
          accept = 1'b1;
          if (addr_io) begin
            next_state = IO_WAIT;
          end else begin
            ram_en = 1'b1;
            ram_we = req_write ? mem_wmask : 4'h0;
            if (!req_write && !RAM_DIRECT) next_state = RAM_WS;
          end
        end
      end
      RAM_WS: begin
        mem_rbusy = 1'b1;
        if (ws_last) next_state = IDLE;
      end
      IO_WAIT: begin
        mem_rbusy = !io_we;
        mem_wbusy = io_we;
        if (io_ready || tmo_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_valid <= 1'b0;
      io_we    <= 1'b0;
      io_wmask <= 4'h0;
      io_addr  <= 32'h0;
      io_wdata <= 32'h0;
      tmo_cnt  <= '0;
      ws_cnt   <= 4'h0;
      rdata_q  <= 32'h0;
      src_ram  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (accept) ws_cnt <= 4'h0;
      if (accept && addr_io) begin
        io_addr  <= mem_addr;
        io_wdata <= mem_wdata;
        io_wmask <= mem_wmask;
        io_we    <= req_write;
        io_valid <= 1'b1;
        tmo_cnt  <= '0;
      end
      // Writes leave the read-data source alone so the last read stays visible.
      if (accept && !req_write) src_ram <= !addr_io && RAM_DIRECT;

      if (state == RAM_WS) begin
        if (ws_cnt == 4'h0) rdata_q <= ram_rdata;
        ws_cnt <= ws_cnt + 4'h1;
      end

      if (state == IO_WAIT) begin
        if (io_ready) begin
          io_valid <= 1'b0;
          if (!io_we) rdata_q <= io_rdata;
        end else if (tmo_hit) begin
          io_valid <= 1'b0;
          rdata_q  <= BUS_ERR_DATA;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      if (tmo_hit) bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Directed bench for rv_mem_bridge: one zero-wait and one two-wait-state instance,
// each backed by a small behavioural SRAM.
module tb_rv_mem_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask, b_wmask;
  logic        mem_rstrb, b_rstrb;
  logic        io_ready, err_clr;
  logic [31:0] io_rdata;

  logic [31:0] mem_rdata_a, ram_wdata_a, ram_rdata_a, io_addr_a, io_wdata_a;
  logic        mem_rbusy_a, mem_wbusy_a, ram_en_a, io_valid_a, io_we_a, bus_err_a;
  logic [3:0]  ram_we_a, io_wmask_a;
  logic [13:0] ram_addr_a;

  logic [31:0] mem_rdata_b, ram_wdata_b, ram_rdata_b, io_addr_b, io_wdata_b;
  logic        mem_rbusy_b, mem_wbusy_b, ram_en_b, io_valid_b, io_we_b, bus_err_b;
  logic [3:0]  ram_we_b, io_wmask_b;
  logic [13:0] ram_addr_b;

  int total = 0;
  int bad   = 0;

  rv_mem_bridge #(.RAM_WAIT(0), .IO_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata_a), .mem_rbusy(mem_rbusy_a), .mem_wbusy(mem_wbusy_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a),
    .io_valid(io_valid_a), .io_we(io_we_a), .io_wmask(io_wmask_a), .io_addr(io_addr_a),
    .io_wdata(io_wdata_a), .io_ready(io_ready), .io_rdata(io_rdata),
    .bus_err(bus_err_a), .err_clr(err_clr)
  );

  rv_mem_bridge #(.RAM_WAIT(2), .IO_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(b_wmask), .mem_rstrb(b_rstrb),
    .mem_rdata(mem_rdata_b), .mem_rbusy(mem_rbusy_b), .mem_wbusy(mem_wbusy_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b),
    .io_valid(io_valid_b), .io_we(io_we_b), .io_wmask(io_wmask_b), .io_addr(io_addr_b),
    .io_wdata(io_wdata_b), .io_ready(io_ready), .io_rdata(io_rdata),
    .bus_err(bus_err_b), .err_clr(err_clr)
  );

  logic [31:0] sram_a [0:255];
  logic [31:0] sram_b [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_a[i] = 32'h0;
      sram_b[i] = 32'h0;
    end
    ram_rdata_a = 32'h0;
    ram_rdata_b = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_en_a) begin
      for (int i = 0; i < 4; i++)
        if (ram_we_a[i]) sram_a[ram_addr_a[7:0]][8*i +: 8] <= ram_wdata_a[8*i +: 8];
      if (ram_we_a == 4'h0) ram_rdata_a <= sram_a[ram_addr_a[7:0]];
    end
    if (ram_en_b) begin
      for (int i = 0; i < 4; i++)
        if (ram_we_b[i]) sram_b[ram_addr_b[7:0]][8*i +: 8] <= ram_wdata_b[8*i +: 8];
      if (ram_we_b == 4'h0) ram_rdata_b <= sram_b[ram_addr_b[7:0]];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
    b_wmask = 4'h0; b_rstrb = 1'b0; io_ready = 1'b0; io_rdata = 32'h0; err_clr = 1'b0;
    #1 rst = 1'b0;
    mem_rstrb = 1'b1;
    #2;
    check("rst_rdata",  mem_rdata_a, 32'h0);
    check("rst_rbusy",  mem_rbusy_a, 0);
    check("rst_wbusy",  mem_wbusy_a, 0);
    check("rst_ioval",  io_valid_a, 0);
    check("rst_buserr", bus_err_a, 0);
    check("rst_ram_en", ram_en_a, 0);
    next();
    check("rst_ram_en2", ram_en_a, 0);
    mem_rstrb = 1'b0;
    rst = 1'b1;
    next();

    // Full-word RAM write then read, zero wait states
    mem_addr = 32'h100; mem_wdata = 32'h12345678; mem_wmask = 4'hF;
    #1;
    check("w_ram_en",   ram_en_a, 1);
    check("w_ram_we",   ram_we_a, 4'hF);
    check("w_ram_addr", ram_addr_a, 14'h40);
    check("w_wbusy",    mem_wbusy_a, 0);
    next();
    mem_wmask = 4'h0;
    #1;
    check("w_wbusy_after", mem_wbusy_a, 0);
    mem_rstrb = 1'b1;
    #1;
    check("r_ram_en", ram_en_a, 1);
    check("r_ram_we", ram_we_a, 4'h0);
    check("r_rbusy_T", mem_rbusy_a, 0);
    next();
    mem_rstrb = 1'b0;
    #1;
    check("r_rdata",    mem_rdata_a, 32'h12345678);
    check("r_rbusy_T1", mem_rbusy_a, 0);

    // Byte write to byte 1
    mem_addr = 32'h101; mem_wdata = 32'h0000AB00; mem_wmask = 4'b0010;
    #1;
    check("bw_ram_we",   ram_we_a, 4'b0010);
    check("bw_ram_addr", ram_addr_a, 14'h40);
    next();
    mem_wmask = 4'h0; mem_addr = 32'h100; mem_rstrb = 1'b1;
    next();
    mem_rstrb = 1'b0;
    #1;
    check("bw_readback", mem_rdata_a, 32'h1234AB78);

    // IO read answered on the third wait cycle
    mem_addr = 32'h0040_0010; mem_rstrb = 1'b1;
    #1;
    check("io_r_ram_en", ram_en_a, 0);
    next();
    mem_rstrb = 1'b0;
    #1;
    check("io_r_valid_T1", io_valid_a, 1);
    check("io_r_rbusy_T1", mem_rbusy_a, 1);
    check("io_r_addr",     io_addr_a, 32'h0040_0010);
    check("io_r_we",       io_we_a, 0);
    next();
    check("io_r_valid_T2", io_valid_a, 1);
    check("io_r_rbusy_T2", mem_rbusy_a, 1);
    next();
    io_ready = 1'b1; io_rdata = 32'hA5A50001;
    #1;
    check("io_r_valid_T3", io_valid_a, 1);
    check("io_r_rbusy_T3", mem_rbusy_a, 1);
    next();
    io_ready = 1'b0; io_rdata = 32'h0;
    #1;
    check("io_r_rdata_T4", mem_rdata_a, 32'hA5A50001);
    check("io_r_rbusy_T4", mem_rbusy_a, 0);
    check("io_r_valid_T4", io_valid_a, 0);

    // IO read that never completes: eight cycles of io_valid, then error data
    mem_addr = 32'h0040_0020; mem_rstrb = 1'b1;
    next();
    mem_rstrb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("tmo_valid_T%0d", k), io_valid_a, 1);
      next();
    end
    check("tmo_valid_T9",  io_valid_a, 0);
    check("tmo_rbusy_T9",  mem_rbusy_a, 0);
    check("tmo_rdata_T9",  mem_rdata_a, 32'hDEADBEEF);
    check("tmo_buserr_T9", bus_err_a, 1);
    err_clr = 1'b1;
    next();
    err_clr = 1'b0;
    #1;
    check("err_clr", bus_err_a, 0);

    // Clear coincident with a second timeout: set wins
    mem_addr = 32'h0040_0030; mem_rstrb = 1'b1;
    next();
    mem_rstrb = 1'b0;
    repeat (7) next();
    err_clr = 1'b1;
    next();
    err_clr = 1'b0;
    #1;
    check("set_wins", bus_err_a, 1);

    // Two wait-state RAM on dut_b
    mem_addr = 32'h200; mem_wdata = 32'hCAFEF00D; b_wmask = 4'hF;
    #1;
    check("b_w_ram_we",   ram_we_b, 4'hF);
    check("b_w_ram_addr", ram_addr_b, 14'h80);
    next();
    b_wmask = 4'h0; b_rstrb = 1'b1;
    #1;
    check("b_r_ram_en", ram_en_b, 1);
    check("b_r_rbusy_T", mem_rbusy_b, 0);
    next();
    b_rstrb = 1'b0;
    #1;
    check("b_r_rbusy_T1", mem_rbusy_b, 1);
    next();
    check("b_r_rbusy_T2", mem_rbusy_b, 1);
    next();
    check("b_r_rbusy_T3", mem_rbusy_b, 0);
    check("b_r_rdata_T3", mem_rdata_b, 32'hCAFEF00D);

    // Read and write together: only the write happens
    mem_wdata = 32'h11112222; b_wmask = 4'hF; b_rstrb = 1'b1;
    #1;
    check("both_ram_we", ram_we_b, 4'hF);
    next();
    b_wmask = 4'h0; b_rstrb = 1'b0;
    #1;
    check("both_no_rbusy", mem_rbusy_b, 0);
    b_rstrb = 1'b1;
    next();
    b_rstrb = 1'b0;
    next();
    next();
    check("both_readback", mem_rdata_b, 32'h11112222);

    // Reset in the middle of an IO wait, then an IO write after release
    mem_addr = 32'h0040_0040; mem_rstrb = 1'b1;
    next();
    mem_rstrb = 1'b0;
    next();
    check("pre_rst_valid",  io_valid_a, 1);
    check("pre_rst_buserr", bus_err_a, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid",  io_valid_a, 0);
    check("mid_rst_rbusy",  mem_rbusy_a, 0);
    check("mid_rst_buserr", bus_err_a, 0);
    check("mid_rst_rdata",  mem_rdata_a, 32'h0);
    next();
    rst = 1'b1;
    mem_addr = 32'h0040_0050; mem_wdata = 32'h55AA55AA; mem_wmask = 4'hF;
    #1;
    check("io_w_ram_en", ram_en_a, 0);
    next();
    mem_wmask = 4'h0; io_ready = 1'b1;
    #1;
    check("io_w_valid", io_valid_a, 1);
    check("io_w_wbusy", mem_wbusy_a, 1);
    check("io_w_rbusy", mem_rbusy_a, 0);
    check("io_w_we",    io_we_a, 1);
    check("io_w_wdata", io_wdata_a, 32'h55AA55AA);
    check("io_w_wmask", io_wmask_a, 4'hF);
    next();
    io_ready = 1'b0;
    #1;
    check("io_w_valid_after", io_valid_a, 0);
    check("io_w_wbusy_after", mem_wbusy_a, 0);
    check("io_w_buserr",      bus_err_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
